fifo_rd_stream_adapter: RTL and testbench
=========================================

Name: fifo_rd_stream_adapter

Overview:
- Read-side drain engine for the async FIFO, living entirely in the rd_clk domain.
- Pops the FIFO through its rd_en/rdata/empty interface and absorbs the FIFO's 1-cycle read latency in a small skid buffer.
- Presents words downstream on a valid/ready stream.
- Never reads an empty FIFO; counts delivered words; latches a sticky error if the FIFO ever flags underflow.

Parameters:
- DATA_WIDTH, 8, width of FIFO data and stream data
- BUF_DEPTH, 2, skid buffer entries; legal values 2..8
- CNT_WIDTH, 16, width of delivered-word counter

Ports:
- rd_clk  input  1  read-domain clock; all logic on posedge
- rst  input  1  synchronous, active-high reset
- enable  input  1  1 = drain permitted; 0 = no new FIFO reads (in-flight word still captured)
- fifo_empty  input  1  FIFO empty flag (rd_clk domain)
- fifo_rdata  input  DATA_WIDTH  FIFO read data, valid the cycle after rd_en is sampled
- fifo_underflow  input  1  FIFO underflow flag
- fifo_rd_en  output  1  FIFO pop request
- m_valid  output  1  stream data valid
- m_data  output  DATA_WIDTH  stream data (buffer head)
- m_ready  input  1  downstream accept
- word_count  output  CNT_WIDTH  number of stream handshakes since reset, wraps
- err_underflow  output  1  sticky; set when fifo_underflow = 1, cleared only by rst

Behaviour:
- Reset, sampled at posedge rd_clk with rst = 1:
  - occupancy = 0, inflight = 0, head/tail pointers = 0, word_count = 0, err_underflow = 0.
  - m_valid = 0 and m_data = 0 the cycle after.
  - fifo_rd_en is forced 0 combinationally while rst = 1.
- Reset mid-operation discards buffered and in-flight words; a FIFO word popped in the reset cycle is lost (by design).
- State: inflight (1 bit) = registered copy of fifo_rd_en.
  - When inflight = 1, fifo_rdata is written at the buffer tail on the next edge; tail advances modulo BUF_DEPTH.
- Pop qualifier: pop = m_valid && m_ready.
- Read issue (combinational): fifo_rd_en = !rst && enable && !fifo_empty && (occupancy + inflight - pop) < BUF_DEPTH.
  - Arithmetic is done in $clog2(BUF_DEPTH)+2 bits so no negatives or overflow.
  - fifo_empty = 1 always forces fifo_rd_en = 0, so no underflow is ever caused by this block.
- Stream side:
  - m_valid = (occupancy != 0); m_data = buf[head], registered storage.
  - On pop: head advances modulo BUF_DEPTH and word_count increments, wrapping from all-ones to 0.
  - m_data/m_valid are held stable while m_valid && !m_ready.
- Occupancy update per edge: occupancy + inflight - pop.
  - Simultaneous capture and pop leaves occupancy unchanged, with correct head/tail wrap.
  - Capture into a full buffer cannot occur; the issue rule guarantees space.
- Latency:
  - fifo_rd_en sampled at edge N → word captured at edge N+1 → m_valid = 1 from edge N+1.
  - That is 2 cycles from issue to first visible data.
- Throughput: 1 word/cycle sustained with m_ready = 1, FIFO non-empty and BUF_DEPTH ≥ 2.
- Backpressure: with m_ready = 0, at most BUF_DEPTH words are buffered and fifo_rd_en then stays 0.
- enable deassert: an already-issued read still lands; buffered words still drain.
- Ordering: strict FIFO order, no duplication or drop (reset excepted).
- err_underflow: set on any cycle with fifo_underflow = 1, regardless of enable.

Test Plan:
- Reset, then fifo_empty = 1 for 20 cycles, enable = 1 → fifo_rd_en never 1, m_valid = 0, word_count = 0.
- FIFO preloaded with 16 words 0x01..0x10, m_ready = 1, enable = 1:
  - fifo_rd_en high for 16 consecutive cycles, deasserted when empty.
  - m_data shows 0x01..0x10 on consecutive cycles, first valid 2 cycles after first rd_en.
  - word_count = 16.
- Same preload, m_ready = 0 → exactly BUF_DEPTH = 2 reads issued, m_valid = 1 with m_data = 0x01 held stable.
  - Then m_ready = 1 → remaining words delivered in order, word_count = 16, no words lost.
- Random m_ready (~50%) with the concurrent writer inserting 50 random words at random delays:
  - All 50 words delivered in write order, word_count = 50, err_underflow = 0.
  - fifo_rd_en never 1 while fifo_empty = 1.
- enable dropped in the same cycle as a read is issued → that word still appears on m_data; no further fifo_rd_en until enable = 1.
- Pulse fifo_underflow for 1 cycle → err_underflow = 1 and stays set; rst = 1 for one edge → err_underflow = 0, word_count = 0, m_valid = 0.

Source files
------------

// File: rtl/fifo_rd_stream_adapter.sv
// Read-side drain engine for the async FIFO: pops words through rd_en/rdata/empty,
// absorbs the 1-cycle read latency in a skid buffer and presents them on a valid/ready stream.
module fifo_rd_stream_adapter #(
    parameter int DATA_WIDTH = 8,
    parameter int BUF_DEPTH  = 2,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  rd_clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rdata,
    input  logic                  fifo_underflow,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    output logic [CNT_WIDTH-1:0]  word_count,
    output logic                  err_underflow
);

    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int OCC_W = $clog2(BUF_DEPTH) + 2;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(BUF_DEPTH - 1);
    localparam logic [OCC_W-1:0] OCC_MAX  = OCC_W'(BUF_DEPTH);

    logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
    logic [PTR_W-1:0]      head;
    logic [PTR_W-1:0]      tail;
    logic [OCC_W-1:0]      occupancy;
    logic [OCC_W-1:0]      occ_next;
    logic                  inflight;
    logic                  pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    assign m_valid = (occupancy != '0);
    assign m_data  = m_valid ? mem[head] : '0;

    // NOTE: every output of this block is assigned on every path, so no latch is inferred.
    always_comb begin
        pop        = m_valid && m_ready;
        occ_next   = occupancy + OCC_W'(inflight) - OCC_W'(pop);
        fifo_rd_en = !rst && enable && !fifo_empty && (occ_next < OCC_MAX);
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge rd_clk) begin
        if (rst) begin
            occupancy     <= '0;
            inflight      <= 1'b0;
            head          <= '0;
            tail          <= '0;
            word_count    <= '0;
            err_underflow <= 1'b0;
        end else begin
            inflight  <= fifo_rd_en;
            occupancy <= occ_next;
            if (inflight) begin
                tail <= next_ptr(tail);
            end
            if (pop) begin
                head       <= next_ptr(head);
                word_count <= word_count + CNT_WIDTH'(1);
            end
            if (fifo_underflow) begin
                err_underflow <= 1'b1;
            end
        end
    end

    // NOTE: storage is not reset; m_data is gated by m_valid so stale entries never show.
    always_ff @(posedge rd_clk) begin
        if (inflight) begin
            mem[tail] <= fifo_rdata;
        end
    end

endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// Self-checking bench for fifo_rd_stream_adapter: queue-based FIFO model feeding the DUT,
// expected-word queue as the stream reference, directed and randomized scenarios.
module tb_fifo_rd_stream_adapter;

    localparam int DW = 8;
    localparam int BD = 2;
    localparam int CW = 16;

    logic          rd_clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic          fifo_empty = 1'b1;
    logic [DW-1:0] fifo_rdata = '0;
    logic          fifo_underflow = 1'b0;
    logic          m_ready = 1'b0;
    logic          fifo_rd_en;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic [CW-1:0] word_count;
    logic          err_underflow;

    fifo_rd_stream_adapter #(.DATA_WIDTH(DW), .BUF_DEPTH(BD), .CNT_WIDTH(CW)) dut (
        .rd_clk        (rd_clk),
        .rst           (rst),
        .enable        (enable),
        .fifo_empty    (fifo_empty),
        .fifo_rdata    (fifo_rdata),
        .fifo_underflow(fifo_underflow),
        .fifo_rd_en    (fifo_rd_en),
        .m_valid       (m_valid),
        .m_data        (m_data),
        .m_ready       (m_ready),
        .word_count    (word_count),
        .err_underflow (err_underflow)
    );

    always #5 rd_clk = ~rd_clk;

    int            n_pass = 0;
    int            n_total = 0;
    int            hs_cnt = 0;
    int            hs_base = 0;
    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] exp_q[$];
    logic          wr_valid = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic [DW-1:0] pop_word;
    logic [DW-1:0] exp_word;
    logic          prev_hold = 1'b0;
    logic [DW-1:0] prev_data = '0;

    // FIFO model: read data appears the cycle after rd_en is sampled
    always @(posedge rd_clk) begin
        if (fifo_rd_en && fifo_q.size() != 0) begin
            pop_word = fifo_q.pop_front();
            fifo_rdata <= pop_word;
        end
        if (wr_valid) fifo_q.push_back(wr_data);
        fifo_empty <= (fifo_q.size() == 0);
    end

    // Stream monitor: order, hold-stability and empty-read checks every cycle
    always @(negedge rd_clk) begin
        if (rst) begin
            prev_hold = 1'b0;
        end else begin
            if (fifo_empty) begin
                n_total++;
                if (fifo_rd_en !== 1'b0) $display("FAIL rd_while_empty: fifo_rd_en=%b expected 0", fifo_rd_en);
                else n_pass++;
            end
            if (prev_hold) begin
                n_total++;
                if (m_valid !== 1'b1 || m_data !== prev_data)
                    $display("FAIL hold_stable: valid=%b data=%h expected valid=1 data=%h", m_valid, m_data, prev_data);
                else n_pass++;
            end
            if (m_valid && m_ready) begin
                hs_cnt++;
                n_total++;
                if (exp_q.size() == 0) begin
                    $display("FAIL stream_extra: got data=%h expected no word", m_data);
                end else begin
                    exp_word = exp_q.pop_front();
                    if (m_data !== exp_word) $display("FAIL stream_order: got %h expected %h", m_data, exp_word);
                    else n_pass++;
                end
            end
            prev_hold = m_valid && !m_ready;
            prev_data = m_data;
        end
    end

    task automatic tick();
        @(posedge rd_clk);
        #1;
    endtask

    task automatic write_word(input logic [DW-1:0] d);
        wr_valid = 1'b1;
        wr_data  = d;
        exp_q.push_back(d);
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic wait_drained(input string name, input int limit);
        int cyc = 0;
        while (exp_q.size() != 0 && cyc < limit) begin
            @(negedge rd_clk);
            cyc++;
        end
        n_total++;
        if (exp_q.size() != 0) $display("FAIL %s_timeout: %0d words left expected 0", name, exp_q.size());
        else n_pass++;
    endtask

    task automatic test_reset();
        tick();
        rst = 1'b1;
        enable = 1'b1;
        @(negedge rd_clk);
        n_total++;
        if (fifo_rd_en !== 1'b0) $display("FAIL reset_rd_en: got %b expected 0", fifo_rd_en); else n_pass++;
        tick();
        rst = 1'b0;
        hs_base = hs_cnt;
        @(negedge rd_clk);
        n_total++;
        if (m_valid !== 1'b0) $display("FAIL reset_m_valid: got %b expected 0", m_valid); else n_pass++;
        n_total++;
        if (m_data !== '0) $display("FAIL reset_m_data: got %h expected 00", m_data); else n_pass++;
        n_total++;
        if (word_count !== '0) $display("FAIL reset_word_count: got %0d expected 0", word_count); else n_pass++;
        n_total++;
        if (err_underflow !== 1'b0) $display("FAIL reset_err: got %b expected 0", err_underflow); else n_pass++;
    endtask

    task automatic test_empty_idle();
        int seen_rd = 0;
        int seen_valid = 0;
        enable = 1'b1;
        m_ready = 1'b1;
        repeat (20) begin
            @(negedge rd_clk);
            if (fifo_rd_en) seen_rd++;
            if (m_valid) seen_valid++;
        end
        n_total++;
        if (seen_rd != 0) $display("FAIL idle_rd_en: got %0d reads expected 0", seen_rd); else n_pass++;
        n_total++;
        if (seen_valid != 0) $display("FAIL idle_m_valid: got %0d valid cycles expected 0", seen_valid); else n_pass++;
        n_total++;
        if (word_count !== CW'(0)) $display("FAIL idle_word_count: got %0d expected 0", word_count); else n_pass++;
    endtask

    task automatic test_stream_preloaded();
        int rd_cnt = 0, first_rd = -1, last_rd = -1;
        int hs = 0, first_hs = -1, last_hs = -1;
        tick();
        enable = 1'b0;
        m_ready = 1'b1;
        for (int i = 1; i <= 16; i++) write_word(DW'(i));
        enable = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge rd_clk);
            if (fifo_rd_en) begin
                rd_cnt++;
                if (first_rd < 0) first_rd = i;
                last_rd = i;
            end
            if (m_valid && m_ready) begin
                hs++;
                if (first_hs < 0) first_hs = i;
                last_hs = i;
            end
        end
        n_total++;
        if (rd_cnt != 16 || last_rd - first_rd != 15)
            $display("FAIL burst_rd_en: got %0d reads over span %0d expected 16 over 15", rd_cnt, last_rd - first_rd);
        else n_pass++;
        n_total++;
        if (first_hs - first_rd != 2) $display("FAIL burst_latency: got %0d cycles expected 2", first_hs - first_rd); else n_pass++;
        n_total++;
        if (hs != 16 || last_hs - first_hs != 15)
            $display("FAIL burst_throughput: got %0d words over span %0d expected 16 over 15", hs, last_hs - first_hs);
        else n_pass++;
        n_total++;
        if (word_count !== CW'(16)) $display("FAIL burst_word_count: got %0d expected 16", word_count); else n_pass++;
        n_total++;
        if (fifo_rd_en !== 1'b0) $display("FAIL burst_rd_en_end: got %b expected 0", fifo_rd_en); else n_pass++;
    endtask

    task automatic test_backpressure();
        int rd_cnt = 0;
        int hs0;
        tick();
        enable = 1'b0;
        m_ready = 1'b0;
        hs0 = hs_cnt;
        for (int i = 1; i <= 16; i++) write_word(DW'(i));
        enable = 1'b1;
        repeat (20) begin
            @(negedge rd_clk);
            if (fifo_rd_en) rd_cnt++;
        end
        n_total++;
        if (rd_cnt != BD) $display("FAIL bp_reads: got %0d expected %0d", rd_cnt, BD); else n_pass++;
        n_total++;
        if (m_valid !== 1'b1 || m_data !== 8'h01)
            $display("FAIL bp_head: got valid=%b data=%h expected valid=1 data=01", m_valid, m_data);
        else n_pass++;
        tick();
        m_ready = 1'b1;
        wait_drained("bp_drain", 100);
        n_total++;
        if (hs_cnt - hs0 != 16) $display("FAIL bp_delivered: got %0d expected 16", hs_cnt - hs0); else n_pass++;
        n_total++;
        if (word_count !== CW'(hs_cnt - hs_base))
            $display("FAIL bp_word_count: got %0d expected %0d", word_count, CW'(hs_cnt - hs_base));
        else n_pass++;
    endtask

    task automatic test_random();
        int hs0;
        logic wr_done = 1'b0;
        tick();
        enable = 1'b1;
        hs0 = hs_cnt;
        fork
            begin
                for (int i = 0; i < 50; i++) begin
                    repeat ($urandom_range(0, 3)) tick();
                    write_word(DW'($urandom));
                end
                wr_done = 1'b1;
            end
            begin
                int guard = 0;
                while ((!wr_done || exp_q.size() != 0) && guard < 3000) begin
                    tick();
                    m_ready = ($urandom_range(0, 1) == 1);
                    guard++;
                end
            end
        join
        m_ready = 1'b1;
        wait_drained("rand_drain", 50);
        n_total++;
        if (hs_cnt - hs0 != 50) $display("FAIL rand_delivered: got %0d expected 50", hs_cnt - hs0); else n_pass++;
        n_total++;
        if (word_count !== CW'(hs_cnt - hs_base))
            $display("FAIL rand_word_count: got %0d expected %0d", word_count, CW'(hs_cnt - hs_base));
        else n_pass++;
        n_total++;
        if (err_underflow !== 1'b0) $display("FAIL rand_err: got %b expected 0", err_underflow); else n_pass++;
    endtask

    task automatic test_enable_drop();
        int hs0;
        int late_rd = 0;
        tick();
        enable = 1'b0;
        m_ready = 1'b1;
        write_word(8'hA1);
        write_word(8'hA2);
        write_word(8'hA3);
        hs0 = hs_cnt;
        enable = 1'b1;
        @(negedge rd_clk);
        n_total++;
        if (fifo_rd_en !== 1'b1) $display("FAIL endrop_issue: got %b expected 1", fifo_rd_en); else n_pass++;
        tick();
        enable = 1'b0;
        repeat (10) begin
            @(negedge rd_clk);
            if (fifo_rd_en) late_rd++;
        end
        n_total++;
        if (late_rd != 0) $display("FAIL endrop_no_read: got %0d reads expected 0", late_rd); else n_pass++;
        n_total++;
        if (hs_cnt - hs0 != 1 || exp_q.size() != 2)
            $display("FAIL endrop_landed: got %0d words (%0d pending) expected 1 (2 pending)", hs_cnt - hs0, exp_q.size());
        else n_pass++;
        tick();
        enable = 1'b1;
        wait_drained("endrop_drain", 40);
    endtask

    task automatic test_underflow();
        tick();
        enable = 1'b0;
        fifo_underflow = 1'b1;
        tick();
        fifo_underflow = 1'b0;
        @(negedge rd_clk);
        n_total++;
        if (err_underflow !== 1'b1) $display("FAIL uf_set: got %b expected 1", err_underflow); else n_pass++;
        repeat (5) @(negedge rd_clk);
        n_total++;
        if (err_underflow !== 1'b1) $display("FAIL uf_sticky: got %b expected 1", err_underflow); else n_pass++;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        hs_base = hs_cnt;
        exp_q.delete();
        @(negedge rd_clk);
        n_total++;
        if (err_underflow !== 1'b0) $display("FAIL uf_reset_err: got %b expected 0", err_underflow); else n_pass++;
        n_total++;
        if (word_count !== '0) $display("FAIL uf_reset_count: got %0d expected 0", word_count); else n_pass++;
        n_total++;
        if (m_valid !== 1'b0) $display("FAIL uf_reset_valid: got %b expected 0", m_valid); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_empty_idle();
        test_stream_preloaded();
        test_backpressure();
        test_random();
        test_enable_drop();
        test_underflow();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
